mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/arb_types.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/arb_priority.sv | 22 ++
 rtl/mem_port_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/arb_types.sv
// Shared types for the two-requester memory port arbiter.
package arb_types;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and physical-port signals around the arbiter.
interface mem_port_arbiter_if;

    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;

    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_rdata;
    logic        d_resp;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    // Arbiter side
    modport slave (
        input  i_read, i_addr,
        input  d_read, d_write, d_addr, d_wdata, d_byte_enable,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable
    );

    // Environment side: requesters and physical memory
    modport master (
        output i_read, i_addr,
        output d_read, d_write, d_addr, d_wdata, d_byte_enable,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable
    );

endinterface

// File: rtl/arb_priority.sv
// Combinational winner selection; on a tie the side not last served wins.
module arb_priority
    import arb_types::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_served,
    output grant_t winner,
    output logic   valid
);

    always_comb begin
        valid  = i_req | d_req;
        winner = GRANT_I;
        if (i_req && d_req) begin
            winner = (last_served == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            winner = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction and data requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data-first.
module mem_port_arbiter
    import arb_types::*;
(
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t  state_q;
    logic        op_write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic   d_req;
    logic   grant_valid;
    grant_t winner;
    grant_t last_served;

    assign d_req = bus.d_read | bus.d_write;

    arb_priority u_priority (
        .i_req       (bus.i_read),
        .d_req       (d_req),
        .last_served (last_served),
        .winner      (winner),
        .valid       (grant_valid)
    );

`ifdef ARB_ROUND_ROBIN_EN
    grant_t last_served_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_served_q <= GRANT_I;
        end else if (state_q == IDLE && grant_valid) begin
            last_served_q <= winner;
        end
    end

    assign last_served = last_served_q;
`else
    // Tie input pinned so that data always wins a simultaneous request.
    assign last_served = GRANT_I;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        if (winner == GRANT_D) begin
                            state_q    <= D_BUSY;
                            // A simultaneous read+write is treated as a write.
                            op_write_q <= bus.d_write;
                            addr_q     <= bus.d_addr;
                            wdata_q    <= bus.d_wdata;
                            be_q       <= bus.d_write ? bus.d_byte_enable : 4'b0000;
                        end else begin
                            state_q    <= I_BUSY;
                            op_write_q <= 1'b0;
                            addr_q     <= bus.i_addr;
                            wdata_q    <= '0;
                            be_q       <= 4'b0000;
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (bus.mem_resp) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_read        = (state_q != IDLE) && !op_write_q;
    assign bus.mem_write       = (state_q != IDLE) && op_write_q;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = be_q;

    // mem_resp outside a BUSY state never reaches either requester.
    assign bus.i_resp  = (state_q == I_BUSY) && bus.mem_resp;
    assign bus.d_resp  = (state_q == D_BUSY) && bus.mem_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule
